debug_cmd_receiver: RTL and testbench
=====================================

Name: debug_cmd_receiver

Overview:
- Host-to-target half of the UART debug link; the register-dump sender is the target-to-host half.
- Consumes bytes from the UART receiver, parses framed debug commands and drives run-mode control (idle/step/continuous), dump requests and a PC breakpoint for the datapath debug unit.
- Returns a one-byte acknowledge/error code for the UART transmitter arbiter.

Parameters:
- TIMEOUT_CYCLES, 1000000: max idle cycles between bytes of one frame before abort.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clock  in  1  system clock
- resetGral  in  1  asynchronous active-high reset
- rxData  in  8  byte from UART receiver
- rxDone  in  1  one-cycle strobe, rxData valid
- sendBusy  in  1  register-dump sender busy
- modeIdle  out  1  halted mode
- modeStep  out  1  single-step mode
- modeCont  out  1  continuous-run mode
- stepPulse  out  1  one-cycle advance request to pipeline
- dumpReq  out  1  one-cycle request to start register dump
- breakAddr  out  32  breakpoint PC
- breakValid  out  1  breakpoint armed
- ackByte  out  8  ack code
- ackValid  out  1  one-cycle strobe, ackByte valid
- cmdError  out  1  one-cycle error strobe

Behaviour:
- Reset (async, immediate):
  - modeIdle=1, modeStep=0, modeCont=0.
  - All pulses 0; breakAddr=0, breakValid=0, ackByte=0.
  - FSM to WAIT_SYNC; pending flags and timeout counter cleared.
  - Reset mid-frame discards the partial frame.
- Frame format: SYNC_BYTE, CMD, then 4 argument bytes (MSB first) for 'b' only.
- FSM states: WAIT_SYNC, WAIT_CMD, ARG (2-bit byte index 0..3), EXEC.
  - WAIT_SYNC: rxDone with rxData==SYNC_BYTE -> WAIT_CMD. Any other byte is ignored silently.
  - WAIT_CMD: latch CMD. CMD 'b' (8'h62) -> ARG with index 0; otherwise -> EXEC.
  - ARG: each rxDone shifts the byte into a 32-bit shadow; after index 3 -> EXEC.
  - EXEC: exactly one cycle, then -> WAIT_SYNC. No byte can arrive in EXEC (UART byte spacing far exceeds 1 cycle).
- Commands, acted on in the EXEC cycle; outputs register one cycle after EXEC:
  - 'i' (8'h69): one-hot mode = idle.
  - 'c' (8'h63): mode = continuous.
  - 's' (8'h73): mode = step; stepPulse=1; dumpReq=1 on the following cycle.
  - 'd' (8'h64): dumpReq=1.
  - 'b': breakAddr=shadow, breakValid=1.
  - 'x' (8'h78): breakValid=0; breakAddr retained.
  - Any other CMD: cmdError=1, ackByte=8'hEE, no state change.
- Ack: a successful command gives ackValid=1 with ackByte=CMD, in the same cycle as the action strobe. For 's', the ack is in the stepPulse cycle.
- Busy interlock:
  - 's' or 'd' with sendBusy=1 sets pendStep/pendDump; mode still updates immediately.
  - Pending pulses (stepPulse then dumpReq, same spacing as above) and the ack are issued in the first cycle sendBusy is observed 0.
  - A second 's'/'d' while either pending flag is set: cmdError, ackByte=8'hEE, dropped.
- Timeout:
  - Counter resets on every rxDone and is held at 0 in WAIT_SYNC.
  - In WAIT_CMD or ARG, when the counter reaches TIMEOUT_CYCLES-1: cmdError=1, ackByte=8'hEE, ackValid=1, FSM -> WAIT_SYNC, shadow discarded.
- Simultaneous events: a timeout and rxDone in the same cycle -> rxDone wins. Modes are always exactly one-hot.
- All strobes are exactly one cycle wide.

Optional Feature:
- Macro CMD_CHECKSUM_EN.
- Defined:
  - Frame carries a trailing byte equal to XOR of CMD and all argument bytes; added state CHK follows WAIT_CMD/ARG.
  - Mismatch: cmdError, ackByte=8'hEE, no action.
  - The timeout also applies in CHK.
- Undefined: no CHK state; EXEC follows directly; frame as above.

Test Plan:
1. Reset, then send A5 63 -> modeCont=1, modeIdle=0; ackValid with ackByte=8'h63; no cmdError.
2. Send A5 62 00 40 00 1C -> breakAddr=32'h0040001C, breakValid=1, ackByte=8'h62. Then send A5 78 -> breakValid=0, breakAddr unchanged.
3. sendBusy=1, send A5 73 -> modeStep=1 immediately, no stepPulse. Send A5 64 -> cmdError, ackByte=8'hEE. Drop sendBusy -> stepPulse next cycle, dumpReq the cycle after, single ack 8'h73.
4. Send A5 62 11 22, then silence for TIMEOUT_CYCLES (bench sets 16) -> cmdError plus ack 8'hEE; breakValid unchanged. Next, A5 69 -> modeIdle=1.
5. Send 00 5A A5 7A -> first two bytes ignored, 7A gives cmdError/8'hEE; mode unchanged.
6. Assert resetGral mid-ARG of a 'b' frame -> outputs at reset values asynchronously. Then A5 73 with sendBusy=0 -> stepPulse, then dumpReq, ack 8'h73. With CMD_CHECKSUM_EN: A5 64 64 accepted, A5 64 00 rejected (8'hEE).

Source files
------------

// File: rtl/debug_cmd_receiver.sv
//==============================================================================
// Module   : debug_cmd_receiver
// Purpose  : Parses framed UART debug commands into run-mode, dump and breakpoint
//            controls. Defining CMD_CHECKSUM_EN adds a trailing XOR check byte.
// Revision : 1.0
//==============================================================================
`default_nettype none

module debug_cmd_receiver #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clock,
  input  logic        resetGral,
  input  logic [7:0]  rxData,
  input  logic        rxDone,
  input  logic        sendBusy,
  output logic        modeIdle,
  output logic        modeStep,
  output logic        modeCont,
  output logic        stepPulse,
  output logic        dumpReq,
  output logic [31:0] breakAddr,
  output logic        breakValid,
  output logic [7:0]  ackByte,
  output logic        ackValid,
  output logic        cmdError
);

  localparam logic [2:0] c_WAIT_SYNC = 3'd0;
  localparam logic [2:0] c_WAIT_CMD  = 3'd1;
  localparam logic [2:0] c_ARG       = 3'd2;
  localparam logic [2:0] c_EXEC      = 3'd3;
`ifdef CMD_CHECKSUM_EN
  localparam logic [2:0] c_CHK       = 3'd4;
  localparam logic [2:0] c_AFTER_HDR = c_CHK;
`else
  localparam logic [2:0] c_AFTER_HDR = c_EXEC;
`endif

  localparam logic [7:0] c_CMD_B   = 8'h62;
  localparam logic [7:0] c_CMD_C   = 8'h63;
  localparam logic [7:0] c_CMD_D   = 8'h64;
  localparam logic [7:0] c_CMD_I   = 8'h69;
  localparam logic [7:0] c_CMD_S   = 8'h73;
  localparam logic [7:0] c_CMD_X   = 8'h78;
  localparam logic [7:0] c_ERR_ACK = 8'hEE;

  localparam int               c_TW        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_TW-1:0]  c_TIME_LAST = c_TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]      r_state;
  logic [7:0]      r_cmd;
  logic [31:0]     r_shadow;
  logic [1:0]      r_argIdx;
  logic [c_TW-1:0] r_timer;
  logic            r_pendStep;
  logic            r_pendDump;
  logic            r_dumpNext;

  logic w_inFrame;
  logic w_timeout;
  logic w_pendAny;
  logic w_chkErr;
  logic w_release;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_chk;
  assign w_inFrame = (r_state == c_WAIT_CMD) || (r_state == c_ARG) || (r_state == c_CHK);
  assign w_chkErr  = (r_state == c_CHK) && rxDone && (rxData != r_chk);
`else
  assign w_inFrame = (r_state == c_WAIT_CMD) || (r_state == c_ARG);
  assign w_chkErr  = 1'b0;
`endif

  // A byte arriving in the expiry cycle keeps the frame alive.
  assign w_timeout = w_inFrame && !rxDone && (r_timer == c_TIME_LAST);
  assign w_pendAny = r_pendStep || r_pendDump;
  // Deferred by a cycle if another ack source owns ackByte this cycle.
  assign w_release = w_pendAny && !sendBusy && (r_state != c_EXEC) && !w_timeout && !w_chkErr;

  always_ff @(posedge clock or posedge resetGral) begin
    if (resetGral) begin
      r_state    <= c_WAIT_SYNC;
      r_cmd      <= 8'h00;
      r_shadow   <= 32'h0;
      r_argIdx   <= 2'd0;
      r_timer    <= '0;
      r_pendStep <= 1'b0;
      r_pendDump <= 1'b0;
      r_dumpNext <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      r_chk      <= 8'h00;
`endif
      modeIdle   <= 1'b1;
      modeStep   <= 1'b0;
      modeCont   <= 1'b0;
      stepPulse  <= 1'b0;
      dumpReq    <= 1'b0;
      breakAddr  <= 32'h0;
      breakValid <= 1'b0;
      ackByte    <= 8'h00;
      ackValid   <= 1'b0;
      cmdError   <= 1'b0;
    end else begin
      stepPulse  <= 1'b0;
      dumpReq    <= r_dumpNext;
      r_dumpNext <= 1'b0;
      ackValid   <= 1'b0;
      cmdError   <= 1'b0;

      if (rxDone || !w_inFrame) r_timer <= '0;
      else                      r_timer <= r_timer + c_TW'(1);

      case (r_state)
        c_WAIT_SYNC: begin
          if (rxDone && (rxData == SYNC_BYTE)) r_state <= c_WAIT_CMD;
        end
        c_WAIT_CMD: begin
          if (rxDone) begin
            r_cmd    <= rxData;
            r_argIdx <= 2'd0;
`ifdef CMD_CHECKSUM_EN
            r_chk    <= rxData;
`endif
            r_state  <= (rxData == c_CMD_B) ? c_ARG : c_AFTER_HDR;
          end
        end
        c_ARG: begin
          if (rxDone) begin
            r_shadow <= {r_shadow[23:0], rxData};
            r_argIdx <= r_argIdx + 2'd1;
`ifdef CMD_CHECKSUM_EN
            r_chk    <= r_chk ^ rxData;
`endif
            if (r_argIdx == 2'd3) r_state <= c_AFTER_HDR;
          end
        end
`ifdef CMD_CHECKSUM_EN
        c_CHK: begin
          if (rxDone) r_state <= w_chkErr ? c_WAIT_SYNC : c_EXEC;
        end
`endif
        c_EXEC: begin
          r_state  <= c_WAIT_SYNC;
          ackValid <= 1'b1;
          ackByte  <= r_cmd;
          case (r_cmd)
            c_CMD_I: {modeIdle, modeStep, modeCont} <= 3'b100;
            c_CMD_C: {modeIdle, modeStep, modeCont} <= 3'b001;
            c_CMD_S, c_CMD_D: begin
              if (w_pendAny) begin
                cmdError <= 1'b1;
                ackByte  <= c_ERR_ACK;
              end else begin
                if (r_cmd == c_CMD_S) {modeIdle, modeStep, modeCont} <= 3'b010;
                if (sendBusy) begin
                  ackValid   <= 1'b0;
                  r_pendStep <= (r_cmd == c_CMD_S);
                  r_pendDump <= (r_cmd == c_CMD_D);
                end else if (r_cmd == c_CMD_S) begin
                  stepPulse  <= 1'b1;
                  r_dumpNext <= 1'b1;
                end else begin
                  dumpReq    <= 1'b1;
                end
              end
            end
            c_CMD_B: begin
              breakAddr  <= r_shadow;
              breakValid <= 1'b1;
            end
            c_CMD_X: breakValid <= 1'b0;
            default: begin
              cmdError <= 1'b1;
              ackByte  <= c_ERR_ACK;
            end
          endcase
        end
        default: r_state <= c_WAIT_SYNC;
      endcase

      if (w_timeout) begin
        r_state  <= c_WAIT_SYNC;
        r_shadow <= 32'h0;
      end

      if (w_timeout || w_chkErr) begin
        cmdError <= 1'b1;
        ackValid <= 1'b1;
        ackByte  <= c_ERR_ACK;
      end

      if (w_release) begin
        ackValid <= 1'b1;
        if (r_pendStep) begin
          ackByte    <= c_CMD_S;
          stepPulse  <= 1'b1;
          r_dumpNext <= 1'b1;
          r_pendStep <= 1'b0;
        end else begin
          ackByte    <= c_CMD_D;
          dumpReq    <= 1'b1;
          r_pendDump <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_debug_cmd_receiver.sv
//==============================================================================
// Module   : tb_debug_cmd_receiver
// Purpose  : Directed self-checking bench for debug_cmd_receiver.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_debug_cmd_receiver;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxDone;
  logic        sendBusy;
  logic        modeIdle, modeStep, modeCont;
  logic        stepPulse, dumpReq;
  logic [31:0] breakAddr;
  logic        breakValid;
  logic [7:0]  ackByte;
  logic        ackValid, cmdError;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         nStep = 0, nDump = 0, nAck = 0, nErr = 0;
  int         stepCyc = 0, dumpCyc = 0;
  logic [7:0] lastAck = 8'h00;

  debug_cmd_receiver #(.TIMEOUT_CYCLES(TOUT), .SYNC_BYTE(8'hA5)) dut (
    .clock(clk), .resetGral(rst), .rxData(rxData), .rxDone(rxDone),
    .sendBusy(sendBusy), .modeIdle(modeIdle), .modeStep(modeStep),
    .modeCont(modeCont), .stepPulse(stepPulse), .dumpReq(dumpReq),
    .breakAddr(breakAddr), .breakValid(breakValid), .ackByte(ackByte),
    .ackValid(ackValid), .cmdError(cmdError)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled on the inactive edge
  always @(negedge clk) begin
    if (stepPulse) begin nStep <= nStep + 1; stepCyc <= cyc; end
    if (dumpReq)   begin nDump <= nDump + 1; dumpCyc <= cyc; end
    if (ackValid)  begin nAck  <= nAck + 1;  lastAck <= ackByte; end
    if (cmdError)  nErr <= nErr + 1;
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk); rxData = b; rxDone = 1'b1;
    @(negedge clk); rxDone = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input bit hasArg, input logic [31:0] arg);
    logic [7:0] chk;
    chk = cmd;
    sendByte(8'hA5);
    sendByte(cmd);
    if (hasArg) begin
      for (int i = 3; i >= 0; i--) begin
        sendByte(arg[i*8 +: 8]);
        chk = chk ^ arg[i*8 +: 8];
      end
    end
`ifdef CMD_CHECKSUM_EN
    sendByte(chk);
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; rxData = 8'h00; rxDone = 1'b0; sendBusy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({modeIdle, modeStep, modeCont, stepPulse, dumpReq, breakValid, ackValid, cmdError} !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_flags got %b want 10000000",
        {modeIdle, modeStep, modeCont, stepPulse, dumpReq, breakValid, ackValid, cmdError});
    end
    checks++;
    if (breakAddr !== 32'h0) begin errors++; $display("FAIL reset_breakAddr got %h want 0", breakAddr); end
    checks++;
    if (ackByte !== 8'h00) begin errors++; $display("FAIL reset_ackByte got %h want 00", ackByte); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode_cont;
    int a0, e0;
    a0 = nAck; e0 = nErr;
    sendFrame(8'h63, 1'b0, 32'h0);
    checks++;
    if ({modeIdle, modeStep, modeCont} !== 3'b001) begin
      errors++; $display("FAIL cont_mode got %b want 001", {modeIdle, modeStep, modeCont});
    end
    checks++;
    if (nAck - a0 !== 1 || lastAck !== 8'h63) begin
      errors++; $display("FAIL cont_ack got n=%0d byte=%h want n=1 byte=63", nAck - a0, lastAck);
    end
    checks++;
    if (nErr - e0 !== 0) begin errors++; $display("FAIL cont_err got %0d want 0", nErr - e0); end
  endtask

  task automatic test_breakpoint;
    sendFrame(8'h62, 1'b1, 32'h0040001C);
    checks++;
    if (breakAddr !== 32'h0040001C || breakValid !== 1'b1) begin
      errors++; $display("FAIL bp_set got %h/%b want 0040001c/1", breakAddr, breakValid);
    end
    checks++;
    if (lastAck !== 8'h62) begin errors++; $display("FAIL bp_ack got %h want 62", lastAck); end
    sendFrame(8'h78, 1'b0, 32'h0);
    checks++;
    if (breakAddr !== 32'h0040001C || breakValid !== 1'b0) begin
      errors++; $display("FAIL bp_clear got %h/%b want 0040001c/0", breakAddr, breakValid);
    end
    checks++;
    if (lastAck !== 8'h78) begin errors++; $display("FAIL bp_clear_ack got %h want 78", lastAck); end
  endtask

  task automatic test_busy_interlock;
    int s0, d0, a0, e0, dropCyc;
    s0 = nStep; d0 = nDump; a0 = nAck; e0 = nErr;
    sendBusy = 1'b1;
    sendFrame(8'h73, 1'b0, 32'h0);
    checks++;
    if ({modeIdle, modeStep, modeCont} !== 3'b010) begin
      errors++; $display("FAIL busy_step_mode got %b want 010", {modeIdle, modeStep, modeCont});
    end
    checks++;
    if (nStep - s0 !== 0 || nAck - a0 !== 0) begin
      errors++; $display("FAIL busy_step_held got step=%0d ack=%0d want 0/0", nStep - s0, nAck - a0);
    end
    sendFrame(8'h64, 1'b0, 32'h0);
    checks++;
    if (nErr - e0 !== 1 || lastAck !== 8'hEE || nDump - d0 !== 0) begin
      errors++; $display("FAIL busy_second_cmd got err=%0d ack=%h dump=%0d want 1/ee/0",
                         nErr - e0, lastAck, nDump - d0);
    end
    a0 = nAck;
    @(negedge clk); sendBusy = 1'b0; dropCyc = cyc;
    repeat (5) @(negedge clk);
    checks++;
    if (nStep - s0 !== 1 || stepCyc !== dropCyc + 1) begin
      errors++; $display("FAIL release_step got n=%0d cyc=%0d want 1/%0d", nStep - s0, stepCyc, dropCyc + 1);
    end
    checks++;
    if (nDump - d0 !== 1 || dumpCyc !== dropCyc + 2) begin
      errors++; $display("FAIL release_dump got n=%0d cyc=%0d want 1/%0d", nDump - d0, dumpCyc, dropCyc + 2);
    end
    checks++;
    if (nAck - a0 !== 1 || lastAck !== 8'h73) begin
      errors++; $display("FAIL release_ack got n=%0d byte=%h want 1/73", nAck - a0, lastAck);
    end
  endtask

  task automatic test_timeout;
    int e0, a0;
    logic bv;
    bv = breakValid; e0 = nErr;
    sendByte(8'hA5); sendByte(8'h62); sendByte(8'h11); sendByte(8'h22);
    a0 = nAck;
    repeat (6) @(negedge clk);
    checks++;
    if (nErr - e0 !== 0) begin errors++; $display("FAIL timeout_early got err=%0d want 0", nErr - e0); end
    for (int i = 0; i < 40 && nErr == e0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (nErr - e0 !== 1 || nAck - a0 !== 1 || lastAck !== 8'hEE) begin
      errors++; $display("FAIL timeout_err got err=%0d ack=%0d byte=%h want 1/1/ee", nErr - e0, nAck - a0, lastAck);
    end
    checks++;
    if (breakValid !== bv) begin errors++; $display("FAIL timeout_bv got %b want %b", breakValid, bv); end
    sendFrame(8'h69, 1'b0, 32'h0);
    checks++;
    if ({modeIdle, modeStep, modeCont} !== 3'b100 || lastAck !== 8'h69) begin
      errors++; $display("FAIL after_timeout_idle got %b/%h want 100/69", {modeIdle, modeStep, modeCont}, lastAck);
    end
  endtask

  task automatic test_bad_cmd;
    int e0;
    e0 = nErr;
    sendByte(8'h00); sendByte(8'h5A);
    checks++;
    if (nErr - e0 !== 0) begin errors++; $display("FAIL junk_ignored got err=%0d want 0", nErr - e0); end
    sendFrame(8'h7A, 1'b0, 32'h0);
    checks++;
    if (nErr - e0 !== 1 || lastAck !== 8'hEE) begin
      errors++; $display("FAIL bad_cmd got err=%0d ack=%h want 1/ee", nErr - e0, lastAck);
    end
    checks++;
    if ({modeIdle, modeStep, modeCont} !== 3'b100) begin
      errors++; $display("FAIL bad_cmd_mode got %b want 100", {modeIdle, modeStep, modeCont});
    end
  endtask

  task automatic test_reset_mid_frame;
    int s0, d0;
    sendFrame(8'h62, 1'b1, 32'h12345678);
    sendFrame(8'h63, 1'b0, 32'h0);
    checks++;
    if (breakValid !== 1'b1 || modeCont !== 1'b1) begin
      errors++; $display("FAIL prereset_state got bv=%b cont=%b want 1/1", breakValid, modeCont);
    end
    sendByte(8'hA5); sendByte(8'h62); sendByte(8'h12);
    @(negedge clk); #2 rst = 1'b1; #1;
    checks++;
    if ({modeIdle, modeStep, modeCont, breakValid} !== 4'b1000 || breakAddr !== 32'h0 || ackByte !== 8'h00) begin
      errors++; $display("FAIL async_reset got %b/%h/%h want 1000/0/00",
                         {modeIdle, modeStep, modeCont, breakValid}, breakAddr, ackByte);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    s0 = nStep; d0 = nDump;
    sendFrame(8'h73, 1'b0, 32'h0);
    checks++;
    if (nStep - s0 !== 1 || nDump - d0 !== 1 || dumpCyc !== stepCyc + 1) begin
      errors++; $display("FAIL post_reset_step got step=%0d dump=%0d gap=%0d want 1/1/1",
                         nStep - s0, nDump - d0, dumpCyc - stepCyc);
    end
    checks++;
    if (lastAck !== 8'h73 || modeStep !== 1'b1) begin
      errors++; $display("FAIL post_reset_ack got %h/%b want 73/1", lastAck, modeStep);
    end
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_checksum;
    int d0, e0;
    d0 = nDump; e0 = nErr;
    sendByte(8'hA5); sendByte(8'h64); sendByte(8'h64);
    repeat (4) @(negedge clk);
    checks++;
    if (nDump - d0 !== 1 || lastAck !== 8'h64) begin
      errors++; $display("FAIL chk_good got dump=%0d ack=%h want 1/64", nDump - d0, lastAck);
    end
    sendByte(8'hA5); sendByte(8'h64); sendByte(8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (nDump - d0 !== 1 || nErr - e0 !== 1 || lastAck !== 8'hEE) begin
      errors++; $display("FAIL chk_bad got dump=%0d err=%0d ack=%h want 1/1/ee", nDump - d0, nErr - e0, lastAck);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mode_cont();
    test_breakpoint();
    test_busy_interlock();
    test_timeout();
    test_bad_cmd();
    test_reset_mid_frame();
`ifdef CMD_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
